// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle control FSM
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_NOP = 6'h00;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;

  localparam logic [1:0] NPC_SEQ  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JUMP = 2'd2;
  localparam logic [1:0] NPC_RS   = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  // One-hot instruction class; all-zero means the encoding is not supported.
  typedef struct packed {
    logic add;
    logic sub;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
    logic jr;
    logic nop;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - opcode/funct to one-hot instruction class and illegal flag
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    cls,
  output logic       illegal
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  cls.add = 1'b1;
          FN_SUB:  cls.sub = 1'b1;
          FN_JR:   cls.jr  = 1'b1;
          FN_NOP:  cls.nop = 1'b1;
          default: cls     = '0;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls     = '0;
    endcase
  end

  assign illegal = (cls == '0);

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle control FSM for the MIPS-subset core
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic [2:0]       alu_op,
  output logic             alu_src_b,
  output logic             ext_op,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             illegal,
  output logic [2:0]       state_dbg
);

  state_t  state, state_nxt;
  iclass_t cls;
  logic    dec_illegal;
  logic    retire, set_ill;
  logic [2:0] ex_alu_op;
  logic       ex_src_b, ex_ext;

  mc_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  // ALU setup shared by EX and WB so the result stays stable through writeback.
  always_comb begin
    ex_alu_op = ALU_ADD;
    if (cls.sub || cls.beq) ex_alu_op = ALU_SUB;
    if (cls.ori)            ex_alu_op = ALU_OR;
    if (cls.lui)            ex_alu_op = ALU_LUI;
    ex_src_b = cls.ori | cls.lui | cls.lw | cls.sw;
    ex_ext   = cls.lw | cls.sw | cls.beq;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    npc_sel   = NPC_SEQ;
    reg_we    = 1'b0;
    reg_dst   = DST_RT;
    wd_sel    = WD_ALU;
    alu_op    = ALU_ADD;
    alu_src_b = 1'b0;
    ext_op    = 1'b0;
    retire    = 1'b0;
    set_ill   = 1'b0;
    // Holding reset low silences every strobe, including the fetch request.
    if (reset) begin
      case (state)
        S_IF: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we     = 1'b1;
            pc_we     = 1'b1;
            state_nxt = S_ID;
          end
        end
        S_ID: begin
          state_nxt = S_EX;
          if (cls.jal) begin
            reg_we    = 1'b1;
            reg_dst   = DST_RA;
            wd_sel    = WD_PC;
            pc_we     = 1'b1;
            npc_sel   = NPC_JUMP;
            retire    = 1'b1;
            state_nxt = S_IF;
          end else if (cls.jr) begin
            pc_we     = 1'b1;
            npc_sel   = NPC_RS;
            retire    = 1'b1;
            state_nxt = S_IF;
          end else if (cls.nop || dec_illegal) begin
            set_ill   = dec_illegal;
            retire    = 1'b1;
            state_nxt = S_IF;
          end
        end
        S_EX: begin
          alu_op    = ex_alu_op;
          alu_src_b = ex_src_b;
          ext_op    = ex_ext;
          if (cls.beq) begin
            pc_we     = zero;
            npc_sel   = zero ? NPC_BR : NPC_SEQ;
            retire    = 1'b1;
            state_nxt = S_IF;
          end else if (cls.lw || cls.sw) begin
            state_nxt = S_MEM;
          end else begin
            state_nxt = S_WB;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = cls.sw;
          if (dmem_ready) begin
            retire    = cls.sw;
            state_nxt = cls.sw ? S_IF : S_WB;
          end
        end
        S_WB: begin
          reg_we    = 1'b1;
          reg_dst   = (cls.add || cls.sub) ? DST_RD : DST_RT;
          wd_sel    = cls.lw ? WD_DM : WD_ALU;
          alu_op    = ex_alu_op;
          alu_src_b = ex_src_b;
          ext_op    = ex_ext;
          retire    = 1'b1;
          state_nxt = S_IF;
        end
        default: state_nxt = S_IF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IF;
      retire_cnt <= '0;
      illegal    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (retire)  retire_cnt <= retire_cnt + CNT_W'(1);
      if (set_ill) illegal    <= 1'b1;
    end
  end

  assign state_dbg = state;

endmodule
